// File: rtl/l3_mem_pkg.sv
// l3_mem_pkg
//   Shared types for the L3 <-> main-memory request/return queue.
//   - AW, DW        : address and line-data widths
//   - mem_entry_t   : one queued request; bit layout matches D_PUSH
//                     ({we, addr, data}, 89 bits)
//   - mq_state_t    : memory-side handshake FSM states
package l3_mem_pkg;

  localparam int AW = 24;
  localparam int DW = 64;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mq_state_t;

endpackage

// File: rtl/l3_entry_fifo.sv
// l3_entry_fifo
//   Synchronous FIFO of mem_entry_t, DEPTH entries (power of two).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     push        write push_data at the tail (ignored when full)
//     push_data   entry to enqueue
//     pop         drop the head entry (ignored when empty)
//     full/empty  occupancy flags, derived from the registered count
//     count       entries currently stored
//     head        oldest stored entry (meaningful only when !empty)
module l3_entry_fifo
  import l3_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  mem_entry_t                   push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output mem_entry_t                   head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  mem_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l3_mem_queue.sv
// l3_mem_queue
//   Request/return queue between the L3 cache and main memory. Requests
//   (writebacks and line-fill reads) are buffered in FIFO order and issued
//   one at a time over a req/ack handshake; read data is returned to the
//   cache over a valid/ack handshake. Strict FIFO issue means a writeback
//   always reaches memory before any later read of the same line.
//   Ports:
//     CLK, Reset_n          clock, asynchronous active-low reset
//     Push_Valid/D_PUSH     cache offers {we, addr, data}
//     Push_Ready            queue has room (registered Count < DEPTH)
//     Pop_Valid/D_POP       read return {addr, rdata}, held until Pop_Ack
//     Pop_Ack               cache consumes D_POP
//     Mem_Req/WE/Addr/WData memory request, held until Mem_Ack
//     Mem_Ack/Mem_RData     memory completion, read data on the ack cycle
//     Count                 queued entries (excludes the in-flight one)
//     Busy                  Count != 0 or a request/return is outstanding
module l3_mem_queue
  import l3_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        Reset_n,
  input  logic                        Push_Valid,
  input  logic [AW+DW:0]              D_PUSH,
  output logic                        Push_Ready,
  output logic                        Pop_Valid,
  output logic [AW+DW-1:0]            D_POP,
  input  logic                        Pop_Ack,
  output logic                        Mem_Req,
  output logic                        Mem_WE,
  output logic [AW-1:0]               Mem_Addr,
  output logic [DW-1:0]               Mem_WData,
  input  logic                        Mem_Ack,
  input  logic [DW-1:0]               Mem_RData,
  output logic [$clog2(DEPTH+1)-1:0]  Count,
  output logic                        Busy
);

  mq_state_t  state;
  mq_state_t  state_next;
  mem_entry_t push_entry;
  mem_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       dequeue;

  assign push_entry = D_PUSH;
  // Full blocks pushes even if a dequeue lands on the same edge: ready is
  // taken from the registered count only, keeping it off any comb path.
  assign Push_Ready = !fifo_full;
  assign dequeue    = (state == IDLE) && !fifo_empty;
  assign Busy       = (Count != '0) || (state != IDLE);

  l3_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (Reset_n),
    .push      (Push_Valid && Push_Ready),
    .push_data (push_entry),
    .pop       (dequeue),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Count),
    .head      (head)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = REQ;
      REQ:     if (Mem_Ack)     state_next = Mem_WE ? IDLE : RESP;
      RESP:    if (Pop_Ack)     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Memory-side and return-side output registers. The Mem_* fields are
  // loaded once at issue and left untouched until the next issue, so they
  // stay stable for the whole request.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Mem_Req   <= 1'b0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Pop_Valid <= 1'b0;
      D_POP     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dequeue) begin
            Mem_Req   <= 1'b1;
            Mem_WE    <= head.we;
            Mem_Addr  <= head.addr;
            Mem_WData <= head.data;
          end
        end
        REQ: begin
          if (Mem_Ack) begin
            Mem_Req <= 1'b0;
            if (!Mem_WE) begin
              D_POP     <= {Mem_Addr, Mem_RData};
              Pop_Valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (Pop_Ack) Pop_Valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_mem_queue.sv
// tb_l3_mem_queue
//   Scoreboard bench for l3_mem_queue. Stimulus pushes the expected memory
//   request (and, for reads, the expected return) into queues; a memory
//   responder and a return monitor pop and compare whenever the DUT
//   presents a new request or return, and hold acks per the knobs below.
module tb_l3_mem_queue;

  localparam int AW    = 24;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic              CLK = 1'b0;
  logic              Reset_n;
  logic              Push_Valid;
  logic [AW+DW:0]    D_PUSH;
  logic              Push_Ready;
  logic              Pop_Valid;
  logic [AW+DW-1:0]  D_POP;
  logic              Pop_Ack;
  logic              Mem_Req;
  logic              Mem_WE;
  logic [AW-1:0]     Mem_Addr;
  logic [DW-1:0]     Mem_WData;
  logic              Mem_Ack;
  logic [DW-1:0]     Mem_RData;
  logic [CW-1:0]     Count;
  logic              Busy;

  l3_mem_queue #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Push_Valid (Push_Valid),
    .D_PUSH     (D_PUSH),
    .Push_Ready (Push_Ready),
    .Pop_Valid  (Pop_Valid),
    .D_POP      (D_POP),
    .Pop_Ack    (Pop_Ack),
    .Mem_Req    (Mem_Req),
    .Mem_WE     (Mem_WE),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Mem_Ack    (Mem_Ack),
    .Mem_RData  (Mem_RData),
    .Count      (Count),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  req_t             exp_req[$];
  logic [AW+DW-1:0] exp_pop[$];
  logic [DW-1:0]    mem_model [logic [AW-1:0]];

  // Knobs written only by the main sequence.
  bit ack_hold  = 1'b0;
  int ack_delay = 1;
  int pop_delay = 1;
  int ack_grant = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  bit   req_seen = 1'b0;
  int   ack_cnt  = 0;
  int   ack_used = 0;
  req_t cur_req;
  req_t e_req;

  always @(negedge CLK) begin
    if (!Reset_n) begin
      Mem_Ack  = 1'b0;
      req_seen = 1'b0;
      ack_cnt  = 0;
    end else if (Mem_Ack) begin
      Mem_Ack  = 1'b0;
      req_seen = 1'b0;
      check("req_drop_after_ack", 128'(Mem_Req), 128'(0));
    end else if (Mem_Req) begin
      if (!req_seen) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr %0h we %0b expected no request", Mem_Addr, Mem_WE);
        end else begin
          e_req = exp_req.pop_front();
          check("req_we", 128'(Mem_WE), 128'(e_req.we));
          check("req_addr", 128'(Mem_Addr), 128'(e_req.addr));
          if (e_req.we) check("req_wdata", 128'(Mem_WData), 128'(e_req.data));
        end
        if (Mem_WE) mem_model[Mem_Addr] = Mem_WData;
        else        Mem_RData = mem_model.exists(Mem_Addr) ? mem_model[Mem_Addr] : '0;
        cur_req  = {Mem_WE, Mem_Addr, Mem_WData};
        req_seen = 1'b1;
        ack_cnt  = 0;
      end else begin
        check("req_stable", 128'({Mem_WE, Mem_Addr, Mem_WData}), 128'(cur_req));
      end
      if (ack_grant != ack_used) begin
        Mem_Ack = 1'b1;
        ack_used++;
      end else if (!ack_hold) begin
        if (ack_cnt >= ack_delay) Mem_Ack = 1'b1;
        else                      ack_cnt++;
      end
    end
  end

  // ---------------- return monitor ----------------
  bit               pop_seen = 1'b0;
  int               pop_cnt  = 0;
  logic [AW+DW-1:0] cur_pop;

  always @(negedge CLK) begin
    if (!Reset_n) begin
      Pop_Ack  = 1'b0;
      pop_seen = 1'b0;
    end else if (Pop_Ack) begin
      Pop_Ack  = 1'b0;
      pop_seen = 1'b0;
      check("pop_valid_drop", 128'(Pop_Valid), 128'(0));
    end else if (Pop_Valid) begin
      if (!pop_seen) begin
        if (exp_pop.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h expected no return", D_POP);
        end else begin
          check("pop_data", 128'(D_POP), 128'(exp_pop.pop_front()));
        end
        cur_pop  = D_POP;
        pop_seen = 1'b1;
        pop_cnt  = 0;
      end else begin
        check("pop_stable", 128'(D_POP), 128'(cur_pop));
        check("no_req_in_resp", 128'(Mem_Req), 128'(0));
      end
      if (pop_cnt >= pop_delay) Pop_Ack = 1'b1;
      else                      pop_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_entry(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    Push_Valid = 1'b1;
    D_PUSH     = {we, addr, data};
    while (!Push_Ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got Push_Ready=0 for %0d cycles expected 1", n);
    end else begin
      exp_req.push_back({we, addr, data});
      @(negedge CLK);
    end
    Push_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || Pop_Valid || exp_req.size() != 0 || exp_pop.size() != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain_in_time", 128'(n < 500), 128'(1));
    check("idle_no_req", 128'(Mem_Req), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit req_seen_after;
    int n;

    Reset_n    = 1'b0;
    Push_Valid = 1'b0;
    D_PUSH     = '0;
    Pop_Ack    = 1'b0;
    Mem_Ack    = 1'b0;
    Mem_RData  = '0;
    repeat (3) @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_mem_req", 128'(Mem_Req), 128'(0));
    check("rst_pop_valid", 128'(Pop_Valid), 128'(0));
    check("rst_d_pop", 128'(D_POP), 128'(0));
    check("rst_count", 128'(Count), 128'(0));
    check("rst_busy", 128'(Busy), 128'(0));
    check("rst_push_ready", 128'(Push_Ready), 128'(1));

    // 1. Reset mid-REQ with three entries queued behind the in-flight one.
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(1'b1, 24'h00F000 + 24'(i), 64'h55 + 64'(i));
    @(negedge CLK);
    check("t1_count3", 128'(Count), 128'(3));
    check("t1_req_pending", 128'(Mem_Req), 128'(1));
    Reset_n = 1'b0;
    #1;
    check("t1_rst_mem_req", 128'(Mem_Req), 128'(0));
    check("t1_rst_pop_valid", 128'(Pop_Valid), 128'(0));
    check("t1_rst_count", 128'(Count), 128'(0));
    check("t1_rst_busy", 128'(Busy), 128'(0));
    exp_req.delete();
    exp_pop.delete();
    repeat (2) @(negedge CLK);
    Reset_n  = 1'b1;
    ack_hold = 1'b0;
    req_seen_after = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (Mem_Req || Busy) req_seen_after = 1'b1;
    end
    check("t1_quiet_after_reset", 128'(req_seen_after), 128'(0));

    // 2. Single write: Mem_Req two edges after the push, ack after 3 cycles.
    ack_delay = 3;
    push_entry(1'b1, 24'hABCDE0, 64'h1122334455667788);
    check("t2_count_after_push", 128'(Count), 128'(1));
    check("t2_req_not_yet", 128'(Mem_Req), 128'(0));
    @(negedge CLK);
    check("t2_req", 128'(Mem_Req), 128'(1));
    check("t2_we", 128'(Mem_WE), 128'(1));
    check("t2_addr", 128'(Mem_Addr), 128'(24'hABCDE0));
    check("t2_wdata", 128'(Mem_WData), 128'(64'h1122334455667788));
    wait_idle();

    // 3. Read with a return held for 5 cycles.
    mem_model[24'h000100] = 64'hDEADBEEFCAFEF00D;
    ack_delay = 2;
    pop_delay = 5;
    exp_pop.push_back({24'h000100, 64'hDEADBEEFCAFEF00D});
    push_entry(1'b0, 24'h000100, 64'h0);
    wait_idle();

    // 4. Memory stalled: fill the queue behind an in-flight write, then
    //    hold one more push until a single ack frees a slot.
    ack_hold  = 1'b1;
    ack_delay = 0;
    pop_delay = 1;
    for (int i = 0; i < 9; i++) push_entry(1'b1, 24'h001000 + 24'(i), 64'hA0 + 64'(i));
    check("t4_full_count", 128'(Count), 128'(8));
    check("t4_full_ready", 128'(Push_Ready), 128'(0));
    Push_Valid = 1'b1;
    D_PUSH     = {1'b1, 24'h001009, 64'hA9};
    exp_req.push_back({1'b1, 24'h001009, 64'hA9});
    repeat (3) @(negedge CLK);
    check("t4_held_count", 128'(Count), 128'(8));
    check("t4_held_ready", 128'(Push_Ready), 128'(0));
    ack_grant++;
    n = 0;
    while (!Push_Ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t4_ready_after_ack", 128'(Push_Ready), 128'(1));
    @(negedge CLK);
    Push_Valid = 1'b0;
    check("t4_count_after_accept", 128'(Count), 128'(8));
    ack_hold = 1'b0;
    wait_idle();

    // 5. Write then read of the same line: the read must see the new data.
    ack_delay = 1;
    pop_delay = 0;
    exp_pop.push_back({24'h000200, 64'h0F1E2D3C4B5A6978});
    push_entry(1'b1, 24'h000200, 64'h0F1E2D3C4B5A6978);
    push_entry(1'b0, 24'h000200, 64'h0);
    wait_idle();

    // 6. Push on the same edge as a dequeue with four entries queued; the
    //    entries straddle the pointer wrap and must drain in order.
    ack_hold = 1'b1;
    for (int i = 0; i < 5; i++) push_entry(1'b1, 24'h003000 + 24'(i), 64'hC0 + 64'(i));
    check("t6_count4", 128'(Count), 128'(4));
    ack_grant++;
    n = 0;
    while (Mem_Req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t6_ack_taken", 128'(Mem_Req), 128'(0));
    push_entry(1'b1, 24'h003005, 64'hC5);
    check("t6_count_same_edge", 128'(Count), 128'(4));
    ack_hold = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
